// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: state encodings, reset PC default, stall vector bit indices.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_WAIT   = 2'd1,
        S_DONE   = 2'd2,
        S_CANCEL = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int unsigned STALL_PC = 0;
    localparam int unsigned STALL_ID = 2;

    function automatic logic addr_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// SRAM-like instruction bus between the fetch unit (master) and instruction memory (slave).
interface if_fetch_unit_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_rdata, inst_data_ok
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_rdata, inst_data_ok
    );

endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC ownership, one-outstanding bus fetch FSM, IF/ID hold register.
// Optional IF_ADDR_CHECK_EN: misaligned PC skips the bus and reports if_adel_o instead.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    if_fetch_unit_if.master inst_bus,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o,
`ifdef IF_ADDR_CHECK_EN
    output logic        if_adel_o,
`endif
    output logic        stallreq_from_if
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic         r_pend_br;
    logic [31:0]  r_br_target;
    logic         r_inst_req;

    fetch_state_e w_state_nxt;
    logic [31:0]  w_pc_nxt;
    logic         w_pend_nxt;
    logic [31:0]  w_tgt_nxt;
    logic [31:0]  w_seq_pc;
    logic         w_accept;
    logic         w_capture;
    logic [31:0]  w_inst_nxt;
    logic         w_req_ok;
    logic         w_unused_stall;
`ifdef IF_ADDR_CHECK_EN
    logic         r_adel;
    logic         w_adel_set;
`endif

    assign inst_bus.inst_req  = r_inst_req;
    assign inst_bus.inst_addr = r_pc;
    assign stallreq_from_if   = (r_state != S_DONE) && !flush && !rst;
    assign w_unused_stall     = ^{stall[5:3], stall[1]};
    assign w_seq_pc           = r_pend_br ? r_br_target : r_pc + 32'd4;
    assign w_accept           = r_inst_req && inst_bus.inst_addr_ok;
`ifdef IF_ADDR_CHECK_EN
    assign w_req_ok  = addr_aligned(w_pc_nxt);
    assign if_adel_o = r_adel;
`else
    assign w_req_ok  = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend_br;
        w_tgt_nxt   = r_br_target;
        w_capture   = 1'b0;
        w_inst_nxt  = inst_bus.inst_rdata;
`ifdef IF_ADDR_CHECK_EN
        w_adel_set  = 1'b0;
`endif
        if (flush) begin
            // Redirect wins over everything; an accepted-but-unanswered request must drain in S_CANCEL.
            w_pc_nxt   = new_pc;
            w_pend_nxt = 1'b0;
            case (r_state)
                S_REQ:    w_state_nxt = w_accept ? S_CANCEL : S_REQ;
                S_WAIT:   w_state_nxt = inst_bus.inst_data_ok ? S_REQ : S_CANCEL;
                S_DONE:   w_state_nxt = S_REQ;
                S_CANCEL: w_state_nxt = inst_bus.inst_data_ok ? S_REQ : S_CANCEL;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
`ifdef IF_ADDR_CHECK_EN
                    if (!addr_aligned(r_pc)) begin
                        w_state_nxt = S_DONE;
                        w_capture   = 1'b1;
                        w_inst_nxt  = '0;
                        w_adel_set  = 1'b1;
                    end else
`endif
                    if (w_accept) w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (inst_bus.inst_data_ok) begin
                        w_state_nxt = S_DONE;
                        w_capture   = 1'b1;
                    end
                end
                S_DONE: begin
                    if (!stall[STALL_PC]) begin
                        w_pc_nxt    = w_seq_pc;
                        w_pend_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end
                end
                S_CANCEL: begin
                    if (inst_bus.inst_data_ok) w_state_nxt = S_REQ;
                end
            endcase
            // Latched after the PC update so a branch arriving as the delay slot advances is kept.
            if (branch_flag_i && !stall[STALL_ID]) begin
                w_pend_nxt = 1'b1;
                w_tgt_nxt  = branch_target_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_pend_br   <= 1'b0;
            r_br_target <= '0;
            r_inst_req  <= 1'b0;
            if_pc_o     <= '0;
            if_inst_o   <= '0;
            if_valid_o  <= 1'b0;
`ifdef IF_ADDR_CHECK_EN
            r_adel      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_pend_br   <= w_pend_nxt;
            r_br_target <= w_tgt_nxt;
            r_inst_req  <= (w_state_nxt == S_REQ) && w_req_ok;
            if_valid_o  <= (w_state_nxt == S_DONE);
            if (w_capture) begin
                if_pc_o   <= r_pc;
                if_inst_o <= w_inst_nxt;
            end
`ifdef IF_ADDR_CHECK_EN
            r_adel      <= (w_state_nxt == S_DONE) && (w_adel_set || r_adel);
`endif
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed stimulus queues expected bus requests and fetches.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam logic [5:0] HOLD = 6'b000001;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;
    logic        stallreq_from_if;
`ifdef IF_ADDR_CHECK_EN
    logic        if_adel_o;
`endif

    if_fetch_unit_if bus();

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .new_pc           (new_pc),
        .branch_flag_i    (branch_flag_i),
        .branch_target_i  (branch_target_i),
        .inst_bus         (bus),
        .if_pc_o          (if_pc_o),
        .if_inst_o        (if_inst_o),
        .if_valid_o       (if_valid_o),
`ifdef IF_ADDR_CHECK_EN
        .if_adel_o        (if_adel_o),
`endif
        .stallreq_from_if (stallreq_from_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Instruction memory: accepts immediately, answers after lat cycles.
    int unsigned lat = 1;
    int unsigned s_cnt;
    logic [31:0] s_addr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_cnt  <= 0;
            s_addr <= '0;
        end else if (bus.inst_req && bus.inst_addr_ok) begin
            s_addr <= bus.inst_addr;
            s_cnt  <= lat;
        end else if (s_cnt != 0) begin
            s_cnt <= s_cnt - 1;
        end
    end

    assign bus.inst_addr_ok = bus.inst_req;
    assign bus.inst_data_ok = (s_cnt == 1);
    assign bus.inst_rdata   = bus.inst_data_ok ? word_of(s_addr) : '0;

    logic [31:0] exp_req[$];
    fetch_t      exp_fetch[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_req(input logic [31:0] a);
        exp_req.push_back(a);
    endtask

    task automatic expect_fetch(input logic [31:0] pc, input logic [31:0] inst);
        fetch_t f;
        f.pc   = pc;
        f.inst = inst;
        exp_fetch.push_back(f);
    endtask

    always @(negedge clk) begin
        fetch_t f;
        if (!rst) begin
            if (bus.inst_req && bus.inst_addr_ok) begin
                if (exp_req.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL req_unexpected: got %h expected no request", bus.inst_addr);
                end else begin
                    check("req_addr", bus.inst_addr, exp_req.pop_front());
                end
            end
            if (if_valid_o && !prev_valid) begin
                if (exp_fetch.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL fetch_unexpected: got pc %h expected no fetch", if_pc_o);
                end else begin
                    f = exp_fetch.pop_front();
                    check("fetch_pc", if_pc_o, f.pc);
                    check("fetch_inst", if_inst_o, f.inst);
                end
            end
        end
        prev_valid <= if_valid_o;
    end

    task automatic wait_valid(input string name);
        int unsigned i = 0;
        @(negedge clk);
        while (!if_valid_o && i < 50) begin
            @(negedge clk);
            i++;
        end
        if (!if_valid_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: if_valid_o got 0 expected 1 within 50 cycles", name);
        end
    endtask

    task automatic release_one();
        stall = 6'b000000;
        @(posedge clk);
        #2 stall = HOLD;
    endtask

    task automatic flush_to(input logic [31:0] pc);
        flush  = 1'b1;
        new_pc = pc;
        @(posedge clk);
        #2 flush = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        stall           = HOLD;
        flush           = 1'b0;
        new_pc          = '0;
        branch_flag_i   = 1'b0;
        branch_target_i = '0;
        repeat (2) @(negedge clk);
        check("rst_inst_req", {31'd0, bus.inst_req}, 32'd0);
        check("rst_inst_addr", bus.inst_addr, 32'h0);
        check("rst_valid", {31'd0, if_valid_o}, 32'd0);
        check("rst_inst", if_inst_o, 32'h0);
        check("rst_pc", if_pc_o, 32'h0);

        // Sequential fetch and stall hold
        expect_req(32'h0);
        expect_fetch(32'h0, 32'hC0DE_0000);
        rst = 1'b0;
        wait_valid("fetch_0");
        check("stallreq_done", {31'd0, stallreq_from_if}, 32'd0);
        stall = 6'b000111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_pc", if_pc_o, 32'h0);
            check("hold_inst", if_inst_o, 32'hC0DE_0000);
            check("hold_req", {31'd0, bus.inst_req}, 32'd0);
            check("hold_valid", {31'd0, if_valid_o}, 32'd1);
        end
        expect_req(32'h4);
        expect_fetch(32'h4, 32'hC0DE_0004);
        release_one();
        @(negedge clk);
        check("release_req", {31'd0, bus.inst_req}, 32'd1);
        check("release_addr", bus.inst_addr, 32'h4);
        check("stallreq_fetch", {31'd0, stallreq_from_if}, 32'd1);
        wait_valid("fetch_4");

        // Branch during delay-slot fetch
        expect_req(32'h8);
        expect_fetch(32'h8, 32'hC0DE_0008);
        expect_req(32'h100);
        expect_fetch(32'h100, 32'hC0DE_0100);
        stall = 6'b000000;
        @(posedge clk);
        #2 stall = HOLD;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h100;
        @(posedge clk);
        #2 branch_flag_i = 1'b0;
        wait_valid("fetch_8");
        release_one();
        @(negedge clk);
        check("branch_addr", bus.inst_addr, 32'h100);
        wait_valid("fetch_100");

        // Flush while waiting for data
        expect_req(32'h104);
        expect_req(32'h40);
        expect_fetch(32'h40, 32'hC0DE_0040);
        lat = 3;
        release_one();
        @(posedge clk);
        #2 flush = 1'b1;
        new_pc = 32'h40;
        lat    = 1;
        @(posedge clk);
        #2 flush = 1'b0;
        @(negedge clk);
        check("cancel_req", {31'd0, bus.inst_req}, 32'd0);
        check("cancel_stallreq", {31'd0, stallreq_from_if}, 32'd1);
        check("cancel_valid", {31'd0, if_valid_o}, 32'd0);
        wait_valid("fetch_40");

        // Flush and branch in the same cycle
        expect_req(32'h20);
        expect_fetch(32'h20, 32'hC0DE_0020);
        expect_req(32'h24);
        expect_fetch(32'h24, 32'hC0DE_0024);
        flush           = 1'b1;
        new_pc          = 32'h20;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h300;
        @(posedge clk);
        #2 flush = 1'b0;
        branch_flag_i = 1'b0;
        @(negedge clk);
        check("flushbr_addr", bus.inst_addr, 32'h20);
        check("flushbr_valid", {31'd0, if_valid_o}, 32'd0);
        wait_valid("fetch_20");
        release_one();
        @(negedge clk);
        check("flushbr_next", bus.inst_addr, 32'h24);
        wait_valid("fetch_24");

        // PC wrap
        expect_req(32'hFFFF_FFFC);
        expect_fetch(32'hFFFF_FFFC, 32'hC0DE_FFFC);
        expect_req(32'h0);
        expect_fetch(32'h0, 32'hC0DE_0000);
        flush_to(32'hFFFF_FFFC);
        wait_valid("fetch_top");
        release_one();
        @(negedge clk);
        check("wrap_addr", bus.inst_addr, 32'h0);
        wait_valid("fetch_wrap");

`ifdef IF_ADDR_CHECK_EN
        expect_fetch(32'h22, 32'h0);
        flush_to(32'h22);
        @(negedge clk);
        check("adel_no_req", {31'd0, bus.inst_req}, 32'd0);
        wait_valid("fetch_adel");
        check("adel_flag", {31'd0, if_adel_o}, 32'd1);
        check("adel_inst", if_inst_o, 32'h0);
        expect_req(32'h0);
        expect_fetch(32'h0, 32'hC0DE_0000);
        flush_to(32'h0);
        @(negedge clk);
        check("adel_clear", {31'd0, if_adel_o}, 32'd0);
        wait_valid("fetch_after_adel");
`endif

        repeat (3) @(negedge clk);
        check("req_queue_empty", exp_req.size(), 32'd0);
        check("fetch_queue_empty", exp_fetch.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
